// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the scan-out path.
//   *_DEFAULT     : default geometry of the low-resolution framebuffer
//   fetch_state_t : states of the row prefetch FSM
//   idx_width()   : bits needed to index n entries (minimum 1)
// ---------------------------------------------------------------------------
package video_pkg;

    localparam int FB_W_DEFAULT       = 320;
    localparam int FB_H_DEFAULT       = 180;
    localparam int SCALE_LOG2_DEFAULT = 2;
    localparam int PIX_W_DEFAULT      = 8;
    localparam int ADDR_W_DEFAULT     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// ---------------------------------------------------------------------------
// line_buffer_dp
// Ping-pong line storage: two banks of FB_W pixels held in one memory.
// One synchronous write port (fetch side), one registered read port
// (display side); each port selects its bank independently.
//   pixel_clk        : clock
//   wr_en            : write strobe
//   wr_bank, wr_col  : write location
//   wr_data          : pixel to store
//   rd_bank, rd_col  : read location, sampled every cycle
//   rd_data          : pixel at the location sampled on the previous edge
// ---------------------------------------------------------------------------
module line_buffer_dp
    import video_pkg::*;
#(
    parameter  int FB_W  = FB_W_DEFAULT,
    parameter  int PIX_W = PIX_W_DEFAULT,
    localparam int COL_W = idx_width(FB_W)
) (
    input  logic             pixel_clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [COL_W-1:0] wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [COL_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_data
);

    localparam int DEPTH = 2 * FB_W;
    localparam int IDX_W = idx_width(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // FB_W need not be a power of two, so bank 1 starts at offset FB_W.
    function automatic logic [IDX_W-1:0] flat_idx(input logic bank, input logic [COL_W-1:0] col);
        return bank ? IDX_W'(FB_W) + IDX_W'(col) : IDX_W'(col);
    endfunction

    assign wr_idx = flat_idx(wr_bank, wr_col);
    assign rd_idx = flat_idx(rd_bank, rd_col);

    // NOTE: the storage array has no reset; a reset would turn the RAM into
    // thousands of flops, and every entry is rewritten by a fetch before use.
    always_ff @(posedge pixel_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/scanline_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// scanline_fetch_arbiter
// Prefetches framebuffer rows into a ping-pong line buffer ahead of display,
// upscales by pixel/line replication and shares the single framebuffer port
// with the game-logic write requester.
//   pixel_clk, rst         : clock, synchronous active-high reset
//   hpos, vpos, active     : display position and active-video flag
//   fsync                  : one-cycle start-of-frame pulse
//   mem_addr/rd_en/wr_en   : framebuffer port (read data returns next cycle)
//   mem_rdata, mem_wdata   : framebuffer read / write data
//   gw_req/addr/data       : game write request, held until gw_ack
//   gw_ack                 : one-cycle grant, write happens this cycle
//   pix_out, pix_valid     : palette index and delayed active to the encoder
//   underrun               : sticky, a swap caught an unfinished fetch
// ---------------------------------------------------------------------------
module scanline_fetch_arbiter
    import video_pkg::*;
#(
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEFAULT,
    parameter int PIX_W      = PIX_W_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic              active,
    input  logic              fsync,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              mem_wr_en,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic              gw_req,
    input  logic [ADDR_W-1:0] gw_addr,
    input  logic [PIX_W-1:0]  gw_data,
    output logic              gw_ack,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              underrun
);

    localparam int COL_W  = idx_width(FB_W);
    localparam int ROW_W  = idx_width(FB_H);
    localparam int HCOL_W = 12 - SCALE_LOG2;

    fetch_state_t      state;
    logic [COL_W-1:0]  col;            // column being read this cycle
    logic [COL_W-1:0]  wr_col;         // column whose data returns this cycle
    logic              wr_bank;
    logic              wr_pending;
    logic              fetch_bank;
    logic              front;
    logic [ROW_W-1:0]  row;            // framebuffer row shown from front
    logic [ADDR_W-1:0] row_base;       // address of col 0 of the fetching row
    logic [ADDR_W-1:0] next_base;      // address of col 0 of the next row to fetch
    logic              second_pending; // row 1 fetch still owed after fsync
    logic              active_d;
    logic              underrun_q;

    logic              line_end;
    logic              swap;
    logic              fetch_room;
    logic              last_col;
    logic [ROW_W:0]    row_plus2;
    logic [HCOL_W-1:0] hcol;
    logic [COL_W-1:0]  rd_col;
    logic [PIX_W-1:0]  rd_data;
    logic              fetch_owns;
    logic              unused_vpos;

    // -----------------------------------------------------------------------
    // Line-end detection: falling edge of active on the last replicated line
    // of a framebuffer row.
    // -----------------------------------------------------------------------
    assign line_end    = active_d & ~active & (&vpos[SCALE_LOG2-1:0]);
    assign swap        = line_end & (row < ROW_W'(FB_H - 1));
    assign row_plus2   = {1'b0, row} + (ROW_W + 1)'(2);
    assign fetch_room  = row_plus2 < (ROW_W + 1)'(FB_H);
    assign last_col    = (col == COL_W'(FB_W - 1));
    assign unused_vpos = ^vpos[11:SCALE_LOG2];

    // -----------------------------------------------------------------------
    // Fetch FSM, bank/row bookkeeping and the one-cycle-late write pointer.
    // -----------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            wr_col         <= '0;
            wr_bank        <= 1'b0;
            wr_pending     <= 1'b0;
            fetch_bank     <= 1'b0;
            front          <= 1'b0;
            row            <= '0;
            row_base       <= '0;
            next_base      <= '0;
            second_pending <= 1'b0;
            active_d       <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            active_d   <= active;
            // Read data lands one cycle after its address; remember where.
            wr_pending <= (state == FETCH);
            wr_col     <= col;
            wr_bank    <= fetch_bank;

            if (fsync) begin
                // Start of frame wins over everything, including a line end.
                state          <= FETCH;
                col            <= '0;
                fetch_bank     <= 1'b0;
                front          <= 1'b0;
                row            <= '0;
                row_base       <= '0;
                next_base      <= ADDR_W'(FB_W);
                second_pending <= 1'b1;
                underrun_q     <= 1'b0;
            end else if (swap) begin
                front          <= ~front;
                row            <= row + 1'b1;
                second_pending <= 1'b0;
                if (state != IDLE) begin
                    underrun_q <= 1'b1;
                end
                if (fetch_room) begin
                    // The old front becomes the new back buffer.
                    state      <= FETCH;
                    col        <= '0;
                    fetch_bank <= front;
                    row_base   <= next_base;
                    next_base  <= next_base + ADDR_W'(FB_W);
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (second_pending) begin
                            state          <= FETCH;
                            col            <= '0;
                            fetch_bank     <= 1'b1;
                            row_base       <= next_base;
                            next_base      <= next_base + ADDR_W'(FB_W);
                            second_pending <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (last_col) begin
                            state <= DRAIN;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory port arbitration. The fetcher keeps the port through DRAIN, so a
    // game write waits at most FB_W+1 cycles.
    // -----------------------------------------------------------------------
    assign fetch_owns = (state == FETCH) || (state == DRAIN);
    assign gw_ack     = gw_req & ~fetch_owns & ~rst;
    assign mem_rd_en  = (state == FETCH) & ~rst;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        if (mem_rd_en) begin
            mem_addr = row_base + ADDR_W'(col);
        end else if (gw_ack) begin
            mem_addr  = gw_addr;
            mem_wr_en = 1'b1;
            mem_wdata = gw_data;
        end
    end

    // -----------------------------------------------------------------------
    // Display read. The sign bit of hpos stays in hcol so negative columns
    // fall out of range instead of wrapping.
    // -----------------------------------------------------------------------
    assign hcol   = hpos[11:SCALE_LOG2];
    assign rd_col = (hcol < HCOL_W'(FB_W)) ? COL_W'(hcol) : '0;

    line_buffer_dp #(
        .FB_W  (FB_W),
        .PIX_W (PIX_W)
    ) u_line_buffer (
        .pixel_clk (pixel_clk),
        .wr_en     (wr_pending),
        .wr_bank   (wr_bank),
        .wr_col    (wr_col),
        .wr_data   (mem_rdata),
        .rd_bank   (front),
        .rd_col    (rd_col),
        .rd_data   (rd_data)
    );

    assign pix_out   = active_d ? rd_data : '0;
    assign pix_valid = active_d;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scanline_fetch_arbiter
// Directed bench for scanline_fetch_arbiter with a zero-wait framebuffer
// model whose contents are address[7:0]. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_scanline_fetch_arbiter;

    logic               pixel_clk = 1'b0;
    logic               rst;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               active;
    logic               fsync;
    logic [15:0]        mem_addr;
    logic               mem_rd_en;
    logic [7:0]         mem_rdata = 8'h00;
    logic               mem_wr_en;
    logic [7:0]         mem_wdata;
    logic               gw_req;
    logic [15:0]        gw_addr;
    logic [7:0]         gw_data;
    logic               gw_ack;
    logic [7:0]         pix_out;
    logic               pix_valid;
    logic               underrun;

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          both_cnt = 0;
    int          ack_cnt = 0;
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];

    always #5 pixel_clk = ~pixel_clk;

    scanline_fetch_arbiter dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hpos      (hpos),
        .vpos      (vpos),
        .active    (active),
        .fsync     (fsync),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .gw_req    (gw_req),
        .gw_addr   (gw_addr),
        .gw_data   (gw_data),
        .gw_ack    (gw_ack),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .underrun  (underrun)
    );

    // Framebuffer model and port monitor. cyc numbers the rising edges; a
    // falling edge with cyc == N lies in the cycle that ends at edge N.
    always @(posedge pixel_clk) begin
        if (mem_rd_en) begin
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
            mem_rdata <= mem_addr[7:0];
        end
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (gw_ack) ack_cnt++;
        cyc = cyc + 1;
    end

    task automatic wait_reads(input int n);
        for (int i = 0; i < 1000 && rd_addr_q.size() < n; i++) @(negedge pixel_clk);
        repeat (4) @(negedge pixel_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; fsync = 1'b0; active = 1'b0; hpos = '0; vpos = '0;
        gw_req = 1'b0; gw_addr = '0; gw_data = '0;
        repeat (3) @(negedge pixel_clk);
        tests++;
        if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata, gw_ack, pix_out, pix_valid, underrun} !== '0)
            begin failed++; $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h ack=%b pix=%h pv=%b ur=%b, want all 0",
                mem_rd_en, mem_wr_en, mem_addr, mem_wdata, gw_ack, pix_out, pix_valid, underrun); end
        rst = 1'b0;
        repeat (5) @(negedge pixel_clk);
        tests++;
        if (rd_addr_q.size() != 0) begin failed++; $display("FAIL reset_no_reads: got %0d reads, want 0", rd_addr_q.size()); end
    endtask

    task automatic test_fsync_fetch();
        int trig;
        int errs;
        rd_addr_q.delete(); rd_cyc_q.delete(); ack_cnt = 0;
        fsync = 1'b1; trig = cyc;
        @(negedge pixel_clk); fsync = 1'b0;
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'd0)
            begin failed++; $display("FAIL fsync_first_read: rd=%b addr=%0d, want rd=1 addr=0", mem_rd_en, mem_addr); end
        wait_reads(640);
        tests++;
        if (rd_addr_q.size() != 640) begin failed++; $display("FAIL fsync_read_count: got %0d, want 640", rd_addr_q.size()); end
        errs = 0;
        foreach (rd_addr_q[i]) if (rd_addr_q[i] !== 16'(i)) errs++;
        tests++;
        if (errs != 0) begin failed++; $display("FAIL fsync_read_addrs: %0d addresses out of sequence 0..639", errs); end
        tests++;
        if (rd_cyc_q.size() < 321) begin
            failed++; $display("FAIL fsync_read_timing: only %0d reads seen", rd_cyc_q.size());
        end else if (rd_cyc_q[0] != trig + 1 || rd_cyc_q[319] != trig + 320 || rd_cyc_q[320] != trig + 323) begin
            failed++; $display("FAIL fsync_read_timing: first=%0d last0=%0d first1=%0d, want %0d %0d %0d",
                rd_cyc_q[0], rd_cyc_q[319], rd_cyc_q[320], trig + 1, trig + 320, trig + 323);
        end
        tests++;
        if (ack_cnt != 0) begin failed++; $display("FAIL fsync_no_ack: gw_ack high %0d cycles, want 0", ack_cnt); end
    endtask

    task automatic test_display_line0();
        int bad;
        bad = 0;
        vpos = 12'sd0; hpos = 12'sd0; active = 1'b1;
        for (int h = 1; h <= 8; h++) begin
            @(negedge pixel_clk);
            if (pix_out !== 8'((h - 1) / 4) || pix_valid !== 1'b1) begin
                bad++; $display("FAIL line0_pix: hpos=%0d pix=%0d pv=%b, want pix=%0d pv=1", h - 1, pix_out, pix_valid, (h - 1) / 4);
            end
            hpos = 12'(h);
        end
        tests++;
        if (bad != 0) failed++;
        active = 1'b0;
        @(negedge pixel_clk);
        tests++;
        if (pix_out !== 8'd0 || pix_valid !== 1'b0)
            begin failed++; $display("FAIL blank_pix: pix=%0d pv=%b, want 0 0", pix_out, pix_valid); end
        @(negedge pixel_clk);
    endtask

    task automatic test_line_end_swap(output int trig);
        vpos = 12'sd3; active = 1'b1;
        repeat (2) @(negedge pixel_clk);
        active = 1'b0; trig = cyc;
        @(negedge pixel_clk);
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'd640)
            begin failed++; $display("FAIL swap_fetch_start: rd=%b addr=%0d, want rd=1 addr=640", mem_rd_en, mem_addr); end
        vpos = 12'sd4; hpos = 12'sd0; active = 1'b1;
        @(negedge pixel_clk);
        tests++;
        if (pix_out !== 8'h40 || underrun !== 1'b0)
            begin failed++; $display("FAIL line4_pix: pix=%h ur=%b, want pix=40 ur=0", pix_out, underrun); end
        active = 1'b0;
    endtask

    task automatic test_gw_during_fetch(input int trig);
        int req_cyc;
        int ack_cyc;
        while (cyc < trig + 101) @(negedge pixel_clk);
        tests++;
        if (mem_addr !== 16'd740) begin failed++; $display("FAIL gw_col100_addr: addr=%0d, want 740", mem_addr); end
        gw_addr = 16'h1234; gw_data = 8'hAB; gw_req = 1'b1; req_cyc = cyc; ack_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge pixel_clk);
            if (gw_ack === 1'b1) begin ack_cyc = cyc; break; end
        end
        tests++;
        if (ack_cyc != req_cyc + 221) begin failed++; $display("FAIL gw_ack_latency: waited %0d cycles, want 221", ack_cyc - req_cyc); end
        tests++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 16'h1234 || mem_wdata !== 8'hAB)
            begin failed++; $display("FAIL gw_write_port: wr=%b rd=%b addr=%h data=%h, want wr=1 rd=0 addr=1234 data=ab",
                mem_wr_en, mem_rd_en, mem_addr, mem_wdata); end
        @(negedge pixel_clk);
        tests++;
        if (gw_ack !== 1'b1) begin failed++; $display("FAIL gw_back_to_back: ack=%b, want 1", gw_ack); end
        gw_req = 1'b0;
        @(negedge pixel_clk);
    endtask

    task automatic test_underrun();
        int t1;
        vpos = 12'sd7; active = 1'b1;
        repeat (2) @(negedge pixel_clk);
        active = 1'b0; t1 = cyc;
        while (cyc < t1 + 50) @(negedge pixel_clk);
        vpos = 12'sd11; active = 1'b1;
        @(negedge pixel_clk);
        tests++;
        if (mem_addr !== 16'd1010) begin failed++; $display("FAIL underrun_col50_addr: addr=%0d, want 1010", mem_addr); end
        active = 1'b0;
        @(negedge pixel_clk);
        tests++;
        if (underrun !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 16'd1280)
            begin failed++; $display("FAIL underrun_set: ur=%b rd=%b addr=%0d, want ur=1 rd=1 addr=1280", underrun, mem_rd_en, mem_addr); end
        fsync = 1'b1;
        @(negedge pixel_clk); fsync = 1'b0;
        tests++;
        if (underrun !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 16'd0)
            begin failed++; $display("FAIL underrun_clear: ur=%b rd=%b addr=%0d, want ur=0 rd=1 addr=0", underrun, mem_rd_en, mem_addr); end
    endtask

    task automatic test_rst_mid_fetch();
        repeat (20) @(negedge pixel_clk);
        rst = 1'b1; gw_req = 1'b1; gw_addr = 16'h1234; gw_data = 8'hAB;
        @(negedge pixel_clk);
        tests++;
        if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata, gw_ack, pix_out, pix_valid, underrun} !== '0)
            begin failed++; $display("FAIL rst_outputs: rd=%b wr=%b addr=%h wdata=%h ack=%b pix=%h pv=%b ur=%b, want all 0",
                mem_rd_en, mem_wr_en, mem_addr, mem_wdata, gw_ack, pix_out, pix_valid, underrun); end
        gw_req = 1'b0; rst = 1'b0;
        rd_addr_q.delete(); rd_cyc_q.delete();
        repeat (30) @(negedge pixel_clk);
        tests++;
        if (rd_addr_q.size() != 0) begin failed++; $display("FAIL rst_idle: got %0d reads, want 0", rd_addr_q.size()); end
        fsync = 1'b1;
        @(negedge pixel_clk); fsync = 1'b0;
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'd0)
            begin failed++; $display("FAIL rst_refetch: rd=%b addr=%0d, want rd=1 addr=0", mem_rd_en, mem_addr); end
    endtask

    task automatic test_fsync_vs_line_end();
        wait_reads(640);
        vpos = 12'sd3; active = 1'b1;
        repeat (2) @(negedge pixel_clk);
        active = 1'b0;
        repeat (330) @(negedge pixel_clk);
        vpos = 12'sd7; active = 1'b1;
        repeat (2) @(negedge pixel_clk);
        active = 1'b0; fsync = 1'b1;
        rd_addr_q.delete(); rd_cyc_q.delete();
        @(negedge pixel_clk); fsync = 1'b0;
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'd0)
            begin failed++; $display("FAIL coincide_fetch: rd=%b addr=%0d, want rd=1 addr=0", mem_rd_en, mem_addr); end
        wait_reads(640);
        vpos = 12'sd0; hpos = 12'sd4; active = 1'b1;
        @(negedge pixel_clk);
        tests++;
        if (pix_out !== 8'd1) begin failed++; $display("FAIL coincide_front: pix=%0d, want 1", pix_out); end
        active = 1'b0;
        @(negedge pixel_clk);
        tests++;
        if (both_cnt != 0) begin failed++; $display("FAIL port_exclusive: rd and wr together %0d times, want 0", both_cnt); end
    endtask

    initial begin
        int trig;
        test_reset();
        test_fsync_fetch();
        test_display_line0();
        test_line_end_swap(trig);
        test_gw_during_fetch(trig);
        test_underrun();
        test_rst_mid_fetch();
        test_fsync_vs_line_end();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
